// File: rtl/dsp_mac_stream.sv
// Streaming signed pre-add / multiply / accumulate engine with per-frame dump,
// valid/ready flow control, round-half-up right shift and output saturation.
module dsp_mac_stream #(
    parameter int NBA   = 24,
    parameter int NBB   = 18,
    parameter int NBACC = 48,
    parameter int NBP   = 24,
    parameter int S     = 0,
    parameter int LW    = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [LW-1:0]         len,
    input  logic                  presub,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [NBA-1:0] a,
    input  logic signed [NBA-1:0] d,
    input  logic signed [NBB-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NBP-1:0]        p,
    output logic                  sat
);
    // Handshake: a beat moves in on an edge with in_valid & in_ready, a result
    // moves out on an edge with out_valid & out_ready; a blocked output freezes
    // every stage, so in_ready is simply the absence of that stall.
    localparam logic signed [NBACC:0] RND  = (S > 0) ? ((NBACC+1)'(1) <<< ((S > 0) ? S - 1 : 0)) : '0;
    localparam logic signed [NBACC:0] PMAX = (NBACC+1)'({1'b0, {(NBP-1){1'b1}}});
    localparam logic signed [NBACC:0] PMIN = -PMAX - 1;

    logic stall, accept;
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready;

    logic [LW-1:0] cnt, len_q, len_new, len_eff;
    logic          tag_first, tag_last;
    assign len_new   = (len == '0) ? LW'(1) : len;
    assign len_eff   = (cnt == '0) ? len_new : len_q;
    assign tag_first = (cnt == '0);
    assign tag_last  = (cnt == len_eff - LW'(1));

    logic                  v0, f0, l0, ps0;
    logic signed [NBA-1:0] a0, d0;
    logic signed [NBB-1:0] b0, b1;
    logic                  v1, f1, l1;
    logic signed [NBA:0]   ad1;
    logic                  v2, f2, l2;
    logic signed [NBACC-1:0] m2, acc;

    logic signed [NBA:0]     ad_c;
    logic signed [NBACC-1:0] m_c, acc_n;
    logic signed [NBACC:0]   r_c;
    logic                    hi_c, lo_c;

    always_comb begin
        ad_c  = ps0 ? ((NBA+1)'(a0) - (NBA+1)'(d0)) : ((NBA+1)'(a0) + (NBA+1)'(d0));
        m_c   = NBACC'(ad1) * NBACC'(b1);
        acc_n = f2 ? m2 : acc + m2;
        r_c   = ((NBACC+1)'(acc_n) + RND) >>> S;
        hi_c  = (r_c > PMAX);
        lo_c  = (r_c < PMIN);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            len_q <= '0;
        end else if (accept) begin
            if (tag_first) len_q <= len_new;
            cnt <= tag_last ? '0 : cnt + LW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            {v0, f0, l0, ps0} <= '0;
            a0 <= '0; d0 <= '0; b0 <= '0;
            {v1, f1, l1} <= '0;
            ad1 <= '0; b1 <= '0;
            {v2, f2, l2} <= '0;
            m2 <= '0;
        end else if (!stall) begin
            v0 <= accept;
            if (accept) begin
                f0  <= tag_first;
                l0  <= tag_last;
                ps0 <= presub;
                a0  <= a;
                d0  <= d;
                b0  <= b;
            end
            v1  <= v0;
            f1  <= f0;
            l1  <= l0;
            ad1 <= ad_c;
            b1  <= b0;
            v2  <= v1;
            f2  <= f1;
            l2  <= l1;
            m2  <= m_c;
        end
    end

    // Accumulator and result register share the stall; out_valid is re-armed
    // only by a frame's last product, so an unrefilled transfer clears it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc       <= '0;
            p         <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
        end else if (!stall) begin
            if (v2) acc <= acc_n;
            out_valid <= v2 & l2;
            if (v2 && l2) begin
                p   <= NBP'(hi_c ? PMAX : (lo_c ? PMIN : r_c));
                sat <= hi_c | lo_c;
            end
        end
    end
endmodule
